sap_update_queue: RTL and testbench
===================================

Name: sap_update_queue

Overview:
- Update side of the SAp branch predictor; the predictor's fetch side reads the same tables this block writes.
- Collects resolved conditional branch results from the integer issue lanes and buffers them in a FIFO.
- Drains one entry per cycle into the predictor's PHT counter write port and per-address history write port.
- Applies the saturating counter update, repairs history on misprediction, forwards the last write to stale entries, and performs the post-reset table initialisation sweep.

Parameters:
ISSUE_WIDTH, 2, branch-result lanes per cycle (lane 0 older)
QUEUE_DEPTH, 8, FIFO entries (power of 2, >= 2*ISSUE_WIDTH)
ADDR_WIDTH, 32, branch address width
INSN_ADDR_BIT_WIDTH, 2, low address bits dropped for indexing
PHT_INDEX_BITS, 10, PHT index width; index = addr[PHT_INDEX_BITS-1+INSN_ADDR_BIT_WIDTH : INSN_ADDR_BIT_WIDTH]
HIST_INDEX_BITS, 8, history-table index width
HIST_OFFSET, 0, extra shift for history index; index = addr[HIST_INDEX_BITS-1+INSN_ADDR_BIT_WIDTH+HIST_OFFSET : INSN_ADDR_BIT_WIDTH+HIST_OFFSET]
HIST_BITS, 4, local history width (selects counter within PHT entry)
CTR_WIDTH, 2, saturating counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
br_valid  in  ISSUE_WIDTH  per-lane result valid
br_is_cond  in  ISSUE_WIDTH  conditional branch
br_taken  in  ISSUE_WIDTH  executed direction
br_mispred  in  ISSUE_WIDTH  direction mispredicted
br_addr  in  ISSUE_WIDTH*ADDR_WIDTH  branch PC
br_prev_ctr  in  ISSUE_WIDTH*CTR_WIDTH  counter value read at prediction
br_prev_hist  in  ISSUE_WIDTH*HIST_BITS  history read at prediction
br_ready  out  1  queue can accept ISSUE_WIDTH entries this cycle
init_busy  out  1  reset sweep in progress
pht_we  out  1  PHT write enable
pht_init_all  out  1  write wv to every counter of entry wa
pht_wa  out  PHT_INDEX_BITS  PHT write address
pht_wsel  out  HIST_BITS  counter select within entry
pht_wv  out  CTR_WIDTH  counter value
hist_we  out  1  history write enable
hist_wa  out  HIST_INDEX_BITS  history write address
hist_wv  out  HIST_BITS  history value
drop_count  out  16  saturating count of dropped conditional results

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: all outputs 0 except init_busy=1. FIFO is empty, forwarding register is invalid, sweep index is 0.
- Reset asserted mid-operation discards all queued entries; the sweep restarts from index 0 after deassertion.
- Init sweep: while init_busy, one write per cycle at index i = 0 .. 2^max(PHT_INDEX_BITS, HIST_INDEX_BITS) - 1.
  - PHT write (only when i < 2^PHT_INDEX_BITS): pht_we=1, pht_init_all=1, pht_wa=i, pht_wv=2^(CTR_WIDTH-1) (weakly taken).
  - History write (only when i < 2^HIST_INDEX_BITS): hist_we=1, hist_wv=0.
  - init_busy deasserts the cycle after the last index.
- Enqueue:
  - Only lanes with br_valid && br_is_cond are enqueued; non-conditional results are ignored and not counted.
  - Qualifying lanes are pushed in lane order, lane 0 first.
  - br_ready = !init_busy && free slots >= ISSUE_WIDTH.
  - Qualifying lanes presented while !br_ready are dropped whole; drop_count increments by the number of dropped lanes and saturates at 16'hFFFF.
- Drain: when !init_busy and the FIFO is non-empty, pop the head every cycle. Outputs are registered: a result presented in cycle N to an empty queue produces pht_we in cycle N+2.
- Counter forwarding:
  - base = last_ctr if last_valid && last_pht_idx == head.pht_idx && last_sel == head.prev_hist; otherwise base = head.prev_ctr.
  - After each drain write: last_* <= {1, idx, sel, new value}.
- Counter update:
  - Taken: new = (base == 2^CTR_WIDTH - 1) ? base : base + 1.
  - Not taken: new = (base == 0) ? 0 : base - 1.
  - Drive pht_we=1, pht_init_all=0, pht_wa=head.pht_idx, pht_wsel=head.prev_hist, pht_wv=new.
- History repair:
  - If head.mispred: hist_we=1, hist_wa=head.hist_idx, hist_wv=((prev_hist<<1) | taken) truncated to HIST_BITS.
  - Otherwise hist_we=0, because the fetch side has already shifted history speculatively.
- Simultaneous events:
  - Push and pop in the same cycle are both performed; occupancy changes by (pushes - 1).
  - Full FIFO with a concurrent pop still applies the br_ready rule computed from the pre-pop occupancy.
- Wrap-around: read/write pointers are log2(QUEUE_DEPTH)+1 bits; full = MSBs differ and low bits are equal.

Decomposition:
- Shared package (FetchUnitTypes): PHT/history index typedefs, counter typedef, and an SapUpdateEntry struct {pht_idx, hist_idx, prev_ctr, prev_hist, taken, mispred}. Index-extraction functions sit beside the existing index functions.
- One sub-module: sap_update_fifo (multi-push, single-pop circular FIFO with occupancy output). Counter/history arithmetic and the sweep FSM (INIT, RUN) live in the top.

Test Plan:
- Reset release -> init_busy high for exactly 1024 cycles (PHT_INDEX_BITS=10). PHT writes carry wv=2'b10 with pht_init_all=1. History writes carry hist_wv=0 for indices 0..255 only. br_ready=0 throughout.
- Single result (addr=0x100, taken=1, prev_ctr=2, prev_hist=4'b0011, mispred=1) -> two cycles later: pht_wa=0x40, pht_wsel=3, pht_wv=3, hist_wa=0x40, hist_wv=4'b0111.
- Two lanes, same addr and prev_hist, prev_ctr=3, both not-taken -> consecutive writes pht_wv=2 then 1 (forwarding applied); no mispred, so hist_we=0.
- Saturation: prev_ctr=3 taken -> wv=3; prev_ctr=0 not-taken -> wv=0.
- Fill to 7 entries, then present 2 qualifying lanes -> br_ready=0, drop_count 0->2, FIFO contents unchanged; drained order is preserved.
- Assert rst with 5 queued entries -> no pht_we from stale entries; sweep restarts at index 0.

Source files
------------

// File: rtl/sap_update_queue_pkg.sv
// Shared types for the SAp predictor update path: table index, counter and history types,
// the queued update entry, and the saturating counter step.
package sap_update_queue_pkg;

   localparam int ADDR_W      = 32;
   localparam int INSN_ADDR_W = 2;
   localparam int PHT_IDX_W   = 10;
   localparam int HIST_IDX_W  = 8;
   localparam int HIST_OFF    = 0;
   localparam int HIST_W      = 4;
   localparam int CTR_W       = 2;

   typedef logic [PHT_IDX_W-1:0]  pht_idx_t;
   typedef logic [HIST_IDX_W-1:0] hist_idx_t;
   typedef logic [HIST_W-1:0]     hist_t;
   typedef logic [CTR_W-1:0]      ctr_t;

   localparam ctr_t CTR_MAX        = '1;
   localparam ctr_t CTR_WEAK_TAKEN = ctr_t'(1 << (CTR_W - 1));

   typedef struct packed {
      pht_idx_t  pht_idx;
      hist_idx_t hist_idx;
      ctr_t      prev_ctr;
      hist_t     prev_hist;
      logic      taken;
      logic      mispred;
   } sap_update_entry_t;

   function automatic ctr_t ctr_next(input ctr_t base, input logic taken);
      if (taken)
         return (base == CTR_MAX) ? base : base + ctr_t'(1);
      return (base == '0) ? base : base - ctr_t'(1);
   endfunction

endpackage

// File: rtl/sap_update_fifo.sv
// Circular FIFO accepting up to LANES pushes (packed in lane order) and one pop per cycle.
// Extra-MSB pointers distinguish full from empty; count is wr_ptr - rd_ptr.
module sap_update_fifo #(
   parameter int DEPTH = 8,
   parameter int LANES = 2,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LANES-1:0]           push,
   input  logic [LANES*WIDTH-1:0]     push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, n_push;
   logic [AW:0]      slot [LANES];
   logic             do_pop;

   // Each pushing lane lands after all lower-numbered pushing lanes.
   always_comb begin
      n_push = '0;
      for (int l = 0; l < LANES; l++) begin
         slot[l] = wr_ptr + n_push;
         n_push  = n_push + (AW+1)'(push[l]);
      end
   end

   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr[AW-1:0]];
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++)
         if (push[l])
            mem[slot[l][AW-1:0]] <= push_dat[l*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + n_push;
         rd_ptr <= rd_ptr + (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/sap_update_queue.sv
// SAp predictor update side: queues resolved conditional branches, drains one per cycle into
// the PHT counter and history write ports, and sweeps both tables to their initial state after reset.
module sap_update_queue
   import sap_update_queue_pkg::*;
#(
   parameter int ISSUE_WIDTH         = 2,
   parameter int QUEUE_DEPTH         = 8,
   parameter int ADDR_WIDTH          = ADDR_W,
   parameter int INSN_ADDR_BIT_WIDTH = INSN_ADDR_W,
   parameter int PHT_INDEX_BITS      = PHT_IDX_W,
   parameter int HIST_INDEX_BITS     = HIST_IDX_W,
   parameter int HIST_OFFSET         = HIST_OFF,
   parameter int HIST_BITS           = HIST_W,
   parameter int CTR_WIDTH           = CTR_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [ISSUE_WIDTH-1:0]            br_valid,
   input  logic [ISSUE_WIDTH-1:0]            br_is_cond,
   input  logic [ISSUE_WIDTH-1:0]            br_taken,
   input  logic [ISSUE_WIDTH-1:0]            br_mispred,
   input  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] br_addr,
   input  logic [ISSUE_WIDTH*CTR_WIDTH-1:0]  br_prev_ctr,
   input  logic [ISSUE_WIDTH*HIST_BITS-1:0]  br_prev_hist,
   output logic                              br_ready,
   output logic                              init_busy,
   output logic                              pht_we,
   output logic                              pht_init_all,
   output logic [PHT_INDEX_BITS-1:0]         pht_wa,
   output logic [HIST_BITS-1:0]              pht_wsel,
   output logic [CTR_WIDTH-1:0]              pht_wv,
   output logic                              hist_we,
   output logic [HIST_INDEX_BITS-1:0]        hist_wa,
   output logic [HIST_BITS-1:0]              hist_wv,
   output logic [15:0]                       drop_count
);
   localparam int SWEEP_W = (PHT_INDEX_BITS > HIST_INDEX_BITS) ? PHT_INDEX_BITS : HIST_INDEX_BITS;
   localparam int ENTRY_W = $bits(sap_update_entry_t);
   localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [SWEEP_W:0] PHT_SIZE  = (SWEEP_W+1)'(1) << PHT_INDEX_BITS;
   localparam logic [SWEEP_W:0] HIST_SIZE = (SWEEP_W+1)'(1) << HIST_INDEX_BITS;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]                   state;
   logic [SWEEP_W-1:0]           sweep_idx;
   logic [ISSUE_WIDTH-1:0]       qual, push;
   logic [ISSUE_WIDTH*ENTRY_W-1:0] push_dat;
   logic [ENTRY_W-1:0]           head_dat;
   sap_update_entry_t            head;
   logic [CNT_W-1:0]             fifo_count;
   logic                         fifo_empty, fifo_full, pop;
   logic [16:0]                  n_qual, drop_sum;
   logic                         last_valid;
   pht_idx_t                     last_pht_idx;
   hist_t                        last_sel;
   ctr_t                         last_ctr;
   logic                         fwd_hit;
   ctr_t                         base_ctr, new_ctr;
   logic                         unused_addr_bits;

   assign init_busy = (state == ST_INIT);
   assign qual      = br_valid & br_is_cond;
   assign br_ready  = !init_busy && !fifo_full &&
                      (fifo_count <= CNT_W'(QUEUE_DEPTH - ISSUE_WIDTH));
   assign push      = br_ready ? qual : '0;
   assign pop       = !init_busy && !fifo_empty;
   assign unused_addr_bits = ^br_addr;

   for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_lane
      sap_update_entry_t ent;
      assign ent.pht_idx   = br_addr[l*ADDR_WIDTH + INSN_ADDR_BIT_WIDTH +: PHT_INDEX_BITS];
      assign ent.hist_idx  = br_addr[l*ADDR_WIDTH + INSN_ADDR_BIT_WIDTH + HIST_OFFSET +: HIST_INDEX_BITS];
      assign ent.prev_ctr  = br_prev_ctr[l*CTR_WIDTH +: CTR_WIDTH];
      assign ent.prev_hist = br_prev_hist[l*HIST_BITS +: HIST_BITS];
      assign ent.taken     = br_taken[l];
      assign ent.mispred   = br_mispred[l];
      assign push_dat[l*ENTRY_W +: ENTRY_W] = ent;
   end

   always_comb begin
      n_qual = '0;
      for (int l = 0; l < ISSUE_WIDTH; l++)
         n_qual = n_qual + 17'(qual[l]);
   end
   assign drop_sum = {1'b0, drop_count} + n_qual;

   sap_update_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .LANES (ISSUE_WIDTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // The table read at prediction may predate our last write to the same counter.
   assign head     = sap_update_entry_t'(head_dat);
   assign fwd_hit  = last_valid && (last_pht_idx == head.pht_idx) && (last_sel == head.prev_hist);
   assign base_ctr = fwd_hit ? last_ctr : head.prev_ctr;
   assign new_ctr  = ctr_next(base_ctr, head.taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_INIT;
         sweep_idx    <= '0;
         pht_we       <= 1'b0;
         pht_init_all <= 1'b0;
         pht_wa       <= '0;
         pht_wsel     <= '0;
         pht_wv       <= '0;
         hist_we      <= 1'b0;
         hist_wa      <= '0;
         hist_wv      <= '0;
         drop_count   <= '0;
         last_valid   <= 1'b0;
         last_pht_idx <= '0;
         last_sel     <= '0;
         last_ctr     <= '0;
      end else begin
         pht_we       <= 1'b0;
         pht_init_all <= 1'b0;
         hist_we      <= 1'b0;
         if (state == ST_INIT) begin
            if ({1'b0, sweep_idx} < PHT_SIZE) begin
               pht_we       <= 1'b1;
               pht_init_all <= 1'b1;
               pht_wa       <= sweep_idx[PHT_INDEX_BITS-1:0];
               pht_wsel     <= '0;
               pht_wv       <= CTR_WEAK_TAKEN;
            end
            if ({1'b0, sweep_idx} < HIST_SIZE) begin
               hist_we <= 1'b1;
               hist_wa <= sweep_idx[HIST_INDEX_BITS-1:0];
               hist_wv <= '0;
            end
            if (sweep_idx == '1)
               state <= ST_RUN;
            else
               sweep_idx <= sweep_idx + SWEEP_W'(1);
         end else if (pop) begin
            pht_we       <= 1'b1;
            pht_wa       <= head.pht_idx;
            pht_wsel     <= head.prev_hist;
            pht_wv       <= new_ctr;
            last_valid   <= 1'b1;
            last_pht_idx <= head.pht_idx;
            last_sel     <= head.prev_hist;
            last_ctr     <= new_ctr;
            // Correct predictions were already shifted into history at fetch.
            if (head.mispred) begin
               hist_we <= 1'b1;
               hist_wa <= head.hist_idx;
               hist_wv <= {head.prev_hist[HIST_BITS-2:0], head.taken};
            end
         end
         if (!br_ready && (n_qual != '0))
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_sap_update_queue.sv
// Self-checking bench for sap_update_queue against a queue-based reference model.
module tb_sap_update_queue;
   localparam int IW    = 2;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  br_valid, br_is_cond, br_taken, br_mispred;
   logic [63:0] br_addr;
   logic [3:0]  br_prev_ctr;
   logic [7:0]  br_prev_hist;
   logic        br_ready, init_busy, pht_we, pht_init_all, hist_we;
   logic [9:0]  pht_wa;
   logic [3:0]  pht_wsel, hist_wv;
   logic [1:0]  pht_wv;
   logic [7:0]  hist_wa;
   logic [15:0] drop_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int pidx;
      int hidx;
      int ctr;
      int hist;
      bit taken;
      bit mispred;
   } ment_t;

   ment_t mq[$];
   bit    m_last_v;
   int    m_last_idx, m_last_sel, m_last_val;
   int    m_drops;

   always #5 clk = ~clk;

   sap_update_queue dut (
      .clk          (clk),
      .rst          (rst),
      .br_valid     (br_valid),
      .br_is_cond   (br_is_cond),
      .br_taken     (br_taken),
      .br_mispred   (br_mispred),
      .br_addr      (br_addr),
      .br_prev_ctr  (br_prev_ctr),
      .br_prev_hist (br_prev_hist),
      .br_ready     (br_ready),
      .init_busy    (init_busy),
      .pht_we       (pht_we),
      .pht_init_all (pht_init_all),
      .pht_wa       (pht_wa),
      .pht_wsel     (pht_wsel),
      .pht_wv       (pht_wv),
      .hist_we      (hist_we),
      .hist_wa      (hist_wa),
      .hist_wv      (hist_wv),
      .drop_count   (drop_count)
   );

   task automatic model_clear();
      mq.delete();
      m_last_v = 1'b0;
      m_drops  = 0;
   endtask

   // One cycle: present lanes, check br_ready, advance past the edge, check every output.
   task automatic step(input logic [1:0] v, input logic [1:0] c, input logic [1:0] t,
                       input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] c0, input logic [1:0] c1,
                       input logic [3:0] h0, input logic [3:0] h1);
      bit exp_rdy, exp_we;
      ment_t hd, e;
      logic [31:0] a;
      int base, nv;
      br_valid = v; br_is_cond = c; br_taken = t; br_mispred = m;
      br_addr = {a1, a0}; br_prev_ctr = {c1, c0}; br_prev_hist = {h1, h0};
      exp_rdy = (mq.size() <= DEPTH - IW);
      n_tests++;
      if (br_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL br_ready: got %0b expected %0b", br_ready, exp_rdy);
      end
      exp_we = (mq.size() > 0);
      nv = 0;
      if (exp_we) begin
         hd = mq.pop_front();
         base = (m_last_v && m_last_idx == hd.pidx && m_last_sel == hd.hist) ? m_last_val : hd.ctr;
         if (hd.taken) nv = (base == 3) ? 3 : base + 1;
         else          nv = (base == 0) ? 0 : base - 1;
         m_last_v = 1'b1; m_last_idx = hd.pidx; m_last_sel = hd.hist; m_last_val = nv;
      end
      for (int l = 0; l < IW; l++) begin
         if (v[l] && c[l]) begin
            if (exp_rdy) begin
               a = (l == 0) ? a0 : a1;
               e.pidx = int'((a >> 2) % 1024);
               e.hidx = int'((a >> 2) % 256);
               e.ctr = (l == 0) ? int'(c0) : int'(c1);
               e.hist = (l == 0) ? int'(h0) : int'(h1);
               e.taken = t[l];
               e.mispred = m[l];
               mq.push_back(e);
            end else if (m_drops < 65535) begin
               m_drops++;
            end
         end
      end
      @(posedge clk); #1;
      n_tests++;
      if (pht_we !== exp_we) begin
         n_fail++;
         $display("FAIL pht_we: got %0b expected %0b", pht_we, exp_we);
      end
      if (exp_we) begin
         n_tests++;
         if (pht_wa !== 10'(hd.pidx) || pht_wsel !== 4'(hd.hist) || pht_wv !== 2'(nv) || pht_init_all !== 1'b0) begin
            n_fail++;
            $display("FAIL pht_write: got wa=%0h sel=%0h wv=%0d all=%0b expected wa=%0h sel=%0h wv=%0d all=0",
                     pht_wa, pht_wsel, pht_wv, pht_init_all, hd.pidx, hd.hist, nv);
         end
         n_tests++;
         if (hist_we !== hd.mispred) begin
            n_fail++;
            $display("FAIL hist_we: got %0b expected %0b", hist_we, hd.mispred);
         end
         if (hd.mispred) begin
            n_tests++;
            if (hist_wa !== 8'(hd.hidx) || hist_wv !== 4'(((hd.hist << 1) | int'(hd.taken)) % 16)) begin
               n_fail++;
               $display("FAIL hist_write: got wa=%0h wv=%0h expected wa=%0h wv=%0h", hist_wa, hist_wv,
                        hd.hidx, ((hd.hist << 1) | int'(hd.taken)) % 16);
            end
         end
      end
      n_tests++;
      if (drop_count !== 16'(m_drops)) begin
         n_fail++;
         $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drops);
      end
   endtask

   task automatic idle();
      step(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 2'd0, 4'd0, 4'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && mq.size() > 0; i++) idle();
      n_tests++;
      if (mq.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d left expected 0", mq.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      br_valid = '0; br_is_cond = '0; br_taken = '0; br_mispred = '0;
      br_addr = '0; br_prev_ctr = '0; br_prev_hist = '0;
      @(posedge clk); #1;
      n_tests++;
      if (init_busy !== 1'b1 || br_ready !== 1'b0 || pht_we !== 1'b0 || hist_we !== 1'b0 ||
          pht_init_all !== 1'b0 || pht_wa !== 10'd0 || pht_wv !== 2'd0 || hist_wa !== 8'd0 ||
          drop_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%0b rdy=%0b pwe=%0b hwe=%0b all=%0b wa=%0h wv=%0d hwa=%0h drops=%0d expected busy=1 rest 0",
                  init_busy, br_ready, pht_we, hist_we, pht_init_all, pht_wa, pht_wv, hist_wa, drop_count);
      end
   endtask

   // Releases reset and follows the whole table initialisation sweep.
   task automatic test_init_sweep();
      int busy_cnt = 0, pht_cnt = 0, hist_cnt = 0, bad_pht = 0, bad_hist = 0, rdy_bad = 0;
      bit done = 1'b0;
      br_valid = '0; br_is_cond = '0;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
      if (init_busy) busy_cnt++;
      if (br_ready) rdy_bad++;
      for (int c = 0; c < 1100 && !done; c++) begin
         @(posedge clk); #1;
         if (pht_we) begin
            if (pht_wa !== 10'(pht_cnt) || pht_init_all !== 1'b1 || pht_wv !== 2'b10) bad_pht++;
            pht_cnt++;
         end
         if (hist_we) begin
            if (hist_wa !== 8'(hist_cnt) || hist_wv !== 4'd0 || hist_cnt >= 256) bad_hist++;
            hist_cnt++;
         end
         if (init_busy && br_ready) rdy_bad++;
         if (init_busy) busy_cnt++;
         else done = 1'b1;
      end
      n_tests++;
      if (!done) begin n_fail++; $display("FAIL sweep_timeout: got busy after 1100 cycles expected done"); end
      n_tests++;
      if (busy_cnt != 1024) begin n_fail++; $display("FAIL sweep_busy_cycles: got %0d expected 1024", busy_cnt); end
      n_tests++;
      if (pht_cnt != 1024) begin n_fail++; $display("FAIL sweep_pht_writes: got %0d expected 1024", pht_cnt); end
      n_tests++;
      if (hist_cnt != 256) begin n_fail++; $display("FAIL sweep_hist_writes: got %0d expected 256", hist_cnt); end
      n_tests++;
      if (bad_pht != 0) begin n_fail++; $display("FAIL sweep_pht_content: got %0d bad expected 0", bad_pht); end
      n_tests++;
      if (bad_hist != 0) begin n_fail++; $display("FAIL sweep_hist_content: got %0d bad expected 0", bad_hist); end
      n_tests++;
      if (rdy_bad != 0) begin n_fail++; $display("FAIL sweep_br_ready: got %0d ready cycles expected 0", rdy_bad); end
   endtask

   task automatic test_single();
      step(2'b01, 2'b01, 2'b01, 2'b01, 32'h100, 32'h0, 2'd2, 2'd0, 4'b0011, 4'd0);
      idle();
      n_tests++;
      if (pht_we !== 1'b1 || pht_wa !== 10'h40 || pht_wsel !== 4'd3 || pht_wv !== 2'd3 ||
          hist_we !== 1'b1 || hist_wa !== 8'h40 || hist_wv !== 4'b0111) begin
         n_fail++;
         $display("FAIL single: got we=%0b wa=%0h sel=%0d wv=%0d hwe=%0b hwa=%0h hwv=%0h expected 1 40 3 3 1 40 7",
                  pht_we, pht_wa, pht_wsel, pht_wv, hist_we, hist_wa, hist_wv);
      end
   endtask

   task automatic test_forward();
      step(2'b11, 2'b11, 2'b00, 2'b00, 32'h200, 32'h200, 2'd3, 2'd3, 4'd5, 4'd5);
      idle();
      n_tests++;
      if (pht_wv !== 2'd2 || hist_we !== 1'b0) begin
         n_fail++;
         $display("FAIL forward_first: got wv=%0d hwe=%0b expected wv=2 hwe=0", pht_wv, hist_we);
      end
      idle();
      n_tests++;
      if (pht_wv !== 2'd1 || pht_wa !== 10'h80 || hist_we !== 1'b0) begin
         n_fail++;
         $display("FAIL forward_second: got wv=%0d wa=%0h hwe=%0b expected wv=1 wa=80 hwe=0", pht_wv, pht_wa, hist_we);
      end
   endtask

   task automatic test_saturation();
      step(2'b01, 2'b01, 2'b01, 2'b00, 32'h300, 32'h0, 2'd3, 2'd0, 4'd9, 4'd0);
      idle();
      n_tests++;
      if (pht_wv !== 2'd3) begin n_fail++; $display("FAIL sat_high: got %0d expected 3", pht_wv); end
      step(2'b01, 2'b01, 2'b00, 2'b00, 32'h304, 32'h0, 2'd0, 2'd0, 4'd9, 4'd0);
      idle();
      n_tests++;
      if (pht_wv !== 2'd0) begin n_fail++; $display("FAIL sat_low: got %0d expected 0", pht_wv); end
   endtask

   task automatic test_fill_drop();
      for (int i = 0; i < 6; i++)
         step(2'b11, 2'b11, 2'($urandom), 2'($urandom), $urandom, $urandom,
              2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
      n_tests++;
      if (br_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %0b expected 0", br_ready); end
      step(2'b11, 2'b11, 2'b11, 2'b11, 32'hDEAD_0000, 32'hBEEF_0000, 2'd1, 2'd1, 4'd1, 4'd1);
      n_tests++;
      if (drop_count !== 16'd2) begin n_fail++; $display("FAIL fill_drops: got %0d expected 2", drop_count); end
      drain();
   endtask

   task automatic test_random();
      logic [31:0] pool [4];
      pool[0] = 32'h1000; pool[1] = 32'h1004; pool[2] = 32'h2000; pool[3] = 32'h3FF0;
      for (int i = 0; i < 400; i++)
         step(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
              2'($urandom), 2'($urandom),
              pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
              2'($urandom), 2'($urandom),
              4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)));
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++)
         step(2'b11, 2'b11, 2'($urandom), 2'b11, $urandom, $urandom,
              2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
      br_valid = '0; br_is_cond = '0;
      rst = 1'b1;
      #1;
      n_tests++;
      if (pht_we !== 1'b0 || hist_we !== 1'b0 || init_busy !== 1'b1 || br_ready !== 1'b0 || drop_count !== 16'd0) begin
         n_fail++;
         $display("FAIL midreset_state: got pwe=%0b hwe=%0b busy=%0b rdy=%0b drops=%0d expected 0 0 1 0 0",
                  pht_we, hist_we, init_busy, br_ready, drop_count);
      end
      test_init_sweep();
      for (int i = 0; i < 4; i++) idle();
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_single();
      test_forward();
      test_saturation();
      test_fill_drop();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
